hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
Companion to the EX-stage forwarding mux. It resolves the hazards that bypassing cannot cover: load-use, data-memory wait, and taken-branch flush. It keeps a shadow record of the instructions in EX and MEM and drives the pipeline-register enable, bubble and flush controls. It also provides a memory-wait watchdog and saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of the performance counters
MEM_TIMEOUT, 1024, consecutive mem_busy_i cycles before mem_timeout_o is raised (must be at least 2)

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
id_valid_i  in  1  ID stage holds a valid instruction
id_rs1_i  in  5  ID source register 1
id_rs2_i  in  5  ID source register 2
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_used_i  in  1  instruction reads rs2
id_rd_i  in  5  ID destination register
id_reg_write_i  in  1  instruction writes rd
id_mem_read_i  in  1  instruction is a load
ex_branch_taken_i  in  1  EX resolved a taken branch or jump
mem_busy_i  in  1  data memory has not completed; freezes EX/MEM/WB
pc_write_en_o  out  1  PC register update enable
if_id_write_en_o  out  1  IF/ID register load enable
if_id_flush_o  out  1  IF/ID loads a NOP
id_ex_bubble_o  out  1  ID/EX loads a NOP
ex_mem_write_en_o  out  1  EX/MEM register load enable
mem_wb_bubble_o  out  1  MEM/WB loads a NOP
mem_timeout_o  out  1  sticky memory-wait watchdog flag
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 TIMEOUT
stall_cycles_o  out  CNT_W  saturating count of cycles with pc_write_en_o=0
flush_count_o  out  CNT_W  saturating count of cycles with if_id_flush_o=1

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_n_i is asynchronous and active-low.
- Reset state:
  - Shadow EX and MEM slots are invalid.
  - Counters are 0, state is RUN, mem_timeout_o is 0.
  - Control outputs are combinational. With reset state and quiet inputs: pc_write_en_o=1, if_id_write_en_o=1, ex_mem_write_en_o=1, all bubble and flush outputs 0.
- Shadow slot contents: {valid, rd, reg_write, mem_read}.
- Shadow update on a clock edge when mem_busy_i=0:
  - MEM slot takes the EX slot.
  - EX slot takes the ID fields if id_valid_i=1 and neither id_ex_bubble_o nor a branch flush is active; otherwise it becomes invalid.
- Shadow update when mem_busy_i=1: both slots hold.
- load_use = id_valid_i & EX.valid & EX.mem_read & EX.rd!=0 & ((id_rs1_used_i & id_rs1_i==EX.rd) | (id_rs2_used_i & id_rs2_i==EX.rd)).
- A load in the MEM slot never stalls; MEM/WB forwarding covers it.
- Control priority, highest first:
  1. mem_busy_i=1: pc_write_en_o, if_id_write_en_o and ex_mem_write_en_o are 0; mem_wb_bubble_o=1; no flush and no ID/EX bubble; ID/EX holds.
  2. ex_branch_taken_i=1: pc_write_en_o=1 (redirect); if_id_flush_o=1; id_ex_bubble_o=1. Any simultaneous load_use is ignored because the ID instruction is wrong-path.
  3. load_use: pc_write_en_o=0, if_id_write_en_o=0, id_ex_bubble_o=1. Exactly one bubble per load-use, since the load then moves to MEM.
- A branch asserted during mem_busy_i is acted on in the first cycle busy drops; EX holds, so the input stays asserted.
- FSM:
  - RUN to MEM_WAIT when mem_busy_i=1; the wait counter is loaded with 1.
  - MEM_WAIT to RUN when mem_busy_i=0.
  - MEM_WAIT stays while busy, incrementing the wait counter.
  - MEM_WAIT to TIMEOUT when busy and wait counter == MEM_TIMEOUT-1.
  - TIMEOUT sets mem_timeout_o=1 and exits only on reset. Control outputs keep following the priority rules.
  - Wait counter width is clog2(MEM_TIMEOUT+1).
- Counters: stall_cycles_o increments on every edge where pc_write_en_o=0; flush_count_o increments on every edge where if_id_flush_o=1. Both saturate at all-ones.
- Reset mid-stall: all state clears immediately; the first post-reset cycle has no stall unless inputs demand one.

Decomposition:
- Shared pipeline package:
  - FSM state enum {RUN, MEM_WAIT, TIMEOUT}.
  - Shadow-slot struct {valid, rd[4:0], reg_write, mem_read}.
  - Constant REG_ZERO = 5'd0.
- One sub-module: sat_counter (parameter W; inputs inc, clk_i, rst_n_i; output count), instantiated twice.

Test Plan:
- Load-use: lw x5 then add x6,x5,x1 -> one cycle with pc_write_en_o=0, if_id_write_en_o=0, id_ex_bubble_o=1; stall_cycles_o=1; add proceeds on the next cycle.
- No false stall: lw x5 then add x6,x7,x1; and lw x0 then add x6,x0,x0 -> no stall, stall_cycles_o stays 0.
- Memory wait: mem_busy_i high 3 cycles -> ex_mem_write_en_o=0 and mem_wb_bubble_o=1 for 3 cycles; state_o=1 during the wait, then 0; stall_cycles_o=3; shadow slots unchanged.
- Watchdog: MEM_TIMEOUT=4, mem_busy_i held 6 cycles -> state_o=2 and mem_timeout_o=1 from the 5th cycle; both remain after busy drops until rst_n_i pulses low.
- Branch and load-use together: ex_branch_taken_i=1 with a load_use match -> if_id_flush_o=1, id_ex_bubble_o=1, pc_write_en_o=1; flush_count_o=1, stall_cycles_o=0.
- Reset mid-stall: assert rst_n_i low during MEM_WAIT -> state_o=0, counters 0, mem_timeout_o=0 asynchronously; saturation check by preloading via CNT_W=4 and 20 stall cycles -> stall_cycles_o=15.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// hazard_control_unit_pkg : shared FSM state, shadow-slot type and constants
// Revision: 1.0
// ============================================================================
package hazard_control_unit_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } slot_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : W-bit up counter that sticks at all-ones
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// hazard_control_unit : load-use / memory-wait / branch-flush pipeline control
// Revision: 1.0
// ============================================================================
module hazard_control_unit
   import hazard_control_unit_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 1024
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic [4:0]       id_rd_i,
   input  logic             id_reg_write_i,
   input  logic             id_mem_read_i,
   input  logic             ex_branch_taken_i,
   input  logic             mem_busy_i,
   output logic             pc_write_en_o,
   output logic             if_id_write_en_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             ex_mem_write_en_o,
   output logic             mem_wb_bubble_o,
   output logic             mem_timeout_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   slot_t             r_ex;
   slot_t             r_mem_slot;
   state_t            r_state;
   state_t            w_state_nxt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_cnt_nxt;
   logic              w_load_use;
   logic              w_unused_mem;

   assign w_load_use = id_valid_i && r_ex.valid && r_ex.mem_read && (r_ex.rd != REG_ZERO) &&
                       ((id_rs1_used_i && (id_rs1_i == r_ex.rd)) ||
                        (id_rs2_used_i && (id_rs2_i == r_ex.rd)));

   // MEM slot is tracked for completeness; loads there are covered by MEM/WB bypass.
   assign w_unused_mem = ^r_mem_slot;

   always_comb begin
      pc_write_en_o     = 1'b1;
      if_id_write_en_o  = 1'b1;
      if_id_flush_o     = 1'b0;
      id_ex_bubble_o    = 1'b0;
      ex_mem_write_en_o = 1'b1;
      mem_wb_bubble_o   = 1'b0;
      if (mem_busy_i) begin
         pc_write_en_o     = 1'b0;
         if_id_write_en_o  = 1'b0;
         ex_mem_write_en_o = 1'b0;
         mem_wb_bubble_o   = 1'b1;
      end else if (ex_branch_taken_i) begin
         if_id_flush_o  = 1'b1;
         id_ex_bubble_o = 1'b1;
      end else if (w_load_use) begin
         pc_write_en_o    = 1'b0;
         if_id_write_en_o = 1'b0;
         id_ex_bubble_o   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ex       <= '0;
         r_mem_slot <= '0;
      end else if (!mem_busy_i) begin
         r_mem_slot <= r_ex;
         if (id_valid_i && !id_ex_bubble_o && !ex_branch_taken_i) begin
            r_ex <= '{valid: 1'b1, rd: id_rd_i, reg_write: id_reg_write_i,
                      mem_read: id_mem_read_i};
         end else begin
            r_ex <= '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         RUN: begin
            if (mem_busy_i) begin
               w_state_nxt    = MEM_WAIT;
               w_wait_cnt_nxt = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!mem_busy_i) begin
               w_state_nxt = RUN;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_nxt = TIMEOUT;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         TIMEOUT: w_state_nxt = TIMEOUT;
         default: w_state_nxt = RUN;
      endcase
   end

   assign state_o       = r_state;
   assign mem_timeout_o = (r_state == TIMEOUT);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc     (~pc_write_en_o),
      .count   (stall_cycles_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc     (if_id_flush_o),
      .count   (flush_count_o)
   );

endmodule
`default_nettype wire
